multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Central FSM that steps the LEGv8 datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK/NEXT_PC on a single clock.
//  Replaces the two-clock scheme: PC, IR, register file and data memory all run on clk, gated by the strobes below.
//  Sits between Controller (decode flags) and PC / Instruction_Memory / register file / Data_Memory.
//  Adds a data-memory ready handshake with timeout, halt detection, and retired-instruction/cycle counters.
// PARAMETERS
//  HALT_OPCODE  10'h3FF  instruction[31:22] value that stops the machine
//  MEM_TIMEOUT  16       max cycles in MEM without dm_ready before FAULT (>=1)
//  CNT_W        32       width of cycle_count / instr_count
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      asynchronous, active-low; 0 forces IDLE immediately
//  start          in   1      pulse; leaves IDLE for FETCH
//  stop_req       in   1      level; sampled in NEXT_PC, returns to IDLE after current instruction
//  opcode         in   10     instruction[31:22] from IR
//  dec_mem_read   in   1      Controller mem_read_dm
//  dec_mem_write  in   1      Controller mem_write_dm
//  dec_branch     in   1      Controller branch
//  dec_reg_write  in   1      Controller reg_write_rf
//  alu_zero       in   1      ALU zero flag
//  dm_ready       in   1      data memory has completed the access this cycle
//  ir_load        out  1      IR captures Instruction_Memory output
//  pc_write       out  1      PC loads Mux1 output
//  pc_src         out  1      Mux1 select: 1 = branch target (Adder2), 0 = PC+4 (Adder1)
//  rf_write       out  1      register-file write enable
//  wb_sel         out  1      Mux2 select: 1 = data memory, 0 = ALU
//  dm_read        out  1      data-memory read strobe
//  dm_write       out  1      data-memory write strobe
//  busy           out  1      1 in any state except IDLE/HALT/FAULT
//  halted         out  1      1 in HALT
//  fault          out  1      1 in FAULT
//  state          out  3      current state encoding (debug)
//  cycle_count    out  CNT_W  cycles spent while busy
//  instr_count    out  CNT_W  instructions retired
// BEHAVIOUR
//  Reset: state=IDLE; all strobes, busy/halted/fault=0; counters=0; latched flags=0.
//  Outputs are Moore, decoded from the state register and latched flags only (no input-to-output paths).
//  IDLE: start=1 -> FETCH; else stay.
//  FETCH (1 cyc): ir_load=1 -> DECODE.
//  DECODE (1 cyc): latch dec_* into *_q. opcode==HALT_OPCODE -> HALT; dec_mem_read&dec_mem_write -> FAULT; else EXECUTE.
//  EXECUTE (1 cyc): latch alu_zero into zero_q. mem_read_q|mem_write_q -> MEM; else reg_write_q -> WRITEBACK; else NEXT_PC.
//  MEM: dm_read=mem_read_q, dm_write=mem_write_q held every cycle until dm_ready=1 sampled.
//   dm_ready: load -> WRITEBACK, store -> NEXT_PC. Wait counter clears on MEM entry;
//   MEM_TIMEOUT cycles in MEM with no dm_ready -> FAULT (strobes drop same edge). dm_ready on the last allowed cycle wins.
//  WRITEBACK (1 cyc): rf_write=1, wb_sel=mem_read_q -> NEXT_PC.
//  NEXT_PC (1 cyc): pc_write=1, pc_src=branch_q&zero_q; instr_count+=1; stop_req -> IDLE else FETCH.
//  HALT / FAULT: terminal until reset; start ignored; all strobes 0.
//  start outside IDLE ignored. stop_req outside NEXT_PC has no effect.
//  Latency (dm_ready immediate): R-type/ALU-imm 5, load 6, store 5, branch/no-write 4 cycles; +1 per MEM wait cycle.
//  cycle_count increments each cycle busy=1; both counters wrap modulo 2^CNT_W, no saturation.
//  At most one of dm_read/dm_write, and never rf_write with pc_write, in any cycle.
//  Reset asserted mid-instruction: strobes drop asynchronously, no partial PC/RF update is issued.
// STRUCTURE
//  legv8_seq_defs.vh (shared include): state encodings IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4
//   WRITEBACK=5 NEXT_PC=6 HALT=7; FAULT is HALT with fault flag set; HALT_OPCODE default.
//  One sub-module: mem_wait_timer (clear, enable, expired; width from $clog2(MEM_TIMEOUT+1)).
// TESTING
//  ADD (reg_write only), dm_ready=1: start -> states 1,2,3,5,6; rf_write 1 cycle, pc_write 1 cycle, instr_count=1, cycle_count=5.
//  LDUR, dm_ready low 3 cycles: dm_read high 4 cycles, then WRITEBACK with wb_sel=1; total 9 cycles.
//  CBZ dec_branch=1, alu_zero=1 -> NEXT_PC pc_src=1; alu_zero=0 -> pc_src=0; 4 cycles each, no rf_write/dm strobes.
//  STUR, dm_ready never asserted, MEM_TIMEOUT=16: dm_write high exactly 16 cycles, then fault=1, strobes 0, start ignored.
//  opcode=10'h3FF in DECODE -> halted=1 next cycle, instr_count unchanged; decode both mem flags -> fault=1.
//  reset pulled low during MEM with dm_write=1 -> dm_write=0 before next edge; state=IDLE, counters=0; stop_req in NEXT_PC -> IDLE.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and defaults for the LEGv8 multicycle sequencer.
// State codes are fixed because the debug state port exposes them.
package multicycle_sequencer_pkg;

    localparam int unsigned OPCODE_W        = 10;
    localparam int unsigned STATE_W         = 3;
    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned MEM_TIMEOUT_DEF = 16;
    localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 10'h3FF;

    // FAULT shares the HALT encoding and is told apart by the fault flag
    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_NEXT_PC   = 3'd6,
        S_HALT      = 3'd7
    } seq_state_e;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic zero;
    } dec_flags_t;

    typedef struct packed {
        logic ir_load;
        logic pc_write;
        logic pc_src;
        logic rf_write;
        logic wb_sel;
        logic dm_read;
        logic dm_write;
    } strobes_t;

    function automatic logic state_is_busy(input seq_state_e s);
        return !(s == S_IDLE || s == S_HALT);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Controller/datapath-facing signal bundle of the multicycle sequencer.
// master = the side driving decode/handshake inputs, slave = the sequencer.
interface multicycle_sequencer_if #(
    parameter int unsigned CNT_W = multicycle_sequencer_pkg::CNT_W_DEF
);
    logic                                            start;
    logic                                            stop_req;
    logic [multicycle_sequencer_pkg::OPCODE_W-1:0]   opcode;
    logic                                            dec_mem_read;
    logic                                            dec_mem_write;
    logic                                            dec_branch;
    logic                                            dec_reg_write;
    logic                                            alu_zero;
    logic                                            dm_ready;

    logic                                            ir_load;
    logic                                            pc_write;
    logic                                            pc_src;
    logic                                            rf_write;
    logic                                            wb_sel;
    logic                                            dm_read;
    logic                                            dm_write;
    logic                                            busy;
    logic                                            halted;
    logic                                            fault;
    logic [multicycle_sequencer_pkg::STATE_W-1:0]    state;
    logic [CNT_W-1:0]                                cycle_count;
    logic [CNT_W-1:0]                                instr_count;

    modport master (
        output start, stop_req, opcode, dec_mem_read, dec_mem_write,
               dec_branch, dec_reg_write, alu_zero, dm_ready,
        input  ir_load, pc_write, pc_src, rf_write, wb_sel, dm_read, dm_write,
               busy, halted, fault, state, cycle_count, instr_count
    );

    modport slave (
        input  start, stop_req, opcode, dec_mem_read, dec_mem_write,
               dec_branch, dec_reg_write, alu_zero, dm_ready,
        output ir_load, pc_write, pc_src, rf_write, wb_sel, dm_read, dm_write,
               busy, halted, fault, state, cycle_count, instr_count
    );

endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting for data memory; o_expired_c flags the last
// allowed wait cycle so the FSM can fault on that edge unless dm_ready arrives.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);
    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired_c = (r_count == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Single-clock FETCH/DECODE/EXECUTE/MEM/WRITEBACK/NEXT_PC sequencer for the LEGv8
// datapath, with data-memory timeout, halt/fault states and retire/cycle counters.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int unsigned         MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned         CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_sequencer_if.slave  bus
);

    seq_state_e       r_state;
    logic             r_fault;
    logic             r_busy;
    logic             r_halted;
    dec_flags_t       r_flags;
    strobes_t         r_strb;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;

    seq_state_e       w_state_nxt;
    logic             w_fault_nxt;
    dec_flags_t       w_flags_nxt;
    strobes_t         w_strb_nxt;
    logic             w_busy_nxt;
    logic             w_halted_nxt;
    logic             w_instr_inc;
    logic             w_timer_clear;
    logic             w_timer_en;
    logic             w_timer_expired;

    assign w_timer_clear = (r_state != S_MEM);
    assign w_timer_en    = (r_state == S_MEM);

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_clear     (w_timer_clear),
        .i_enable    (w_timer_en),
        .o_expired_c (w_timer_expired)
    );

    // State, latched decode flags and output strobes all update together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_fault  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_flags  <= '0;
            r_strb   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_fault  <= w_fault_nxt;
            r_busy   <= w_busy_nxt;
            r_halted <= w_halted_nxt;
            r_flags  <= w_flags_nxt;
            r_strb   <= w_strb_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fault_nxt  = r_fault;
        w_flags_nxt  = r_flags;
        w_instr_inc  = 1'b0;
        w_strb_nxt   = '0;
        w_busy_nxt   = 1'b0;
        w_halted_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_flags_nxt.mem_read  = bus.dec_mem_read;
                w_flags_nxt.mem_write = bus.dec_mem_write;
                w_flags_nxt.branch    = bus.dec_branch;
                w_flags_nxt.reg_write = bus.dec_reg_write;
                if (bus.opcode == HALT_OPCODE) begin
                    w_state_nxt = S_HALT;
                end else if (bus.dec_mem_read && bus.dec_mem_write) begin
                    w_state_nxt = S_HALT;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                w_flags_nxt.zero = bus.alu_zero;
                if (r_flags.mem_read || r_flags.mem_write) w_state_nxt = S_MEM;
                else if (r_flags.reg_write)                w_state_nxt = S_WRITEBACK;
                else                                       w_state_nxt = S_NEXT_PC;
            end
            S_MEM: begin
                // dm_ready on the final allowed cycle still completes the access
                if (bus.dm_ready) begin
                    w_state_nxt = r_flags.mem_read ? S_WRITEBACK : S_NEXT_PC;
                end else if (w_timer_expired) begin
                    w_state_nxt = S_HALT;
                    w_fault_nxt = 1'b1;
                end
            end
            S_WRITEBACK: begin
                w_state_nxt = S_NEXT_PC;
            end
            S_NEXT_PC: begin
                w_instr_inc = 1'b1;
                w_state_nxt = bus.stop_req ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Moore outputs decoded from the upcoming state so they register with it
        case (w_state_nxt)
            S_FETCH:     w_strb_nxt.ir_load = 1'b1;
            S_MEM: begin
                w_strb_nxt.dm_read  = w_flags_nxt.mem_read;
                w_strb_nxt.dm_write = w_flags_nxt.mem_write;
            end
            S_WRITEBACK: begin
                w_strb_nxt.rf_write = 1'b1;
                w_strb_nxt.wb_sel   = w_flags_nxt.mem_read;
            end
            S_NEXT_PC: begin
                w_strb_nxt.pc_write = 1'b1;
                w_strb_nxt.pc_src   = w_flags_nxt.branch & w_flags_nxt.zero;
            end
            default: ;
        endcase

        w_busy_nxt   = state_is_busy(w_state_nxt);
        w_halted_nxt = (w_state_nxt == S_HALT) && !w_fault_nxt;
    end

    // Free-running counters; wrap naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_busy)      r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_instr_inc) r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign bus.ir_load     = r_strb.ir_load;
    assign bus.pc_write    = r_strb.pc_write;
    assign bus.pc_src      = r_strb.pc_src;
    assign bus.rf_write    = r_strb.rf_write;
    assign bus.wb_sel      = r_strb.wb_sel;
    assign bus.dm_read     = r_strb.dm_read;
    assign bus.dm_write    = r_strb.dm_write;
    assign bus.busy        = r_busy;
    assign bus.halted      = r_halted;
    assign bus.fault       = r_fault;
    assign bus.state       = r_state;
    assign bus.cycle_count = r_cycle_count;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: table of instructions with
// scoreboarded expectations, plus directed halt/fault/timeout/reset sequences.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    typedef struct {
        int          id;
        logic [9:0]  opcode;
        logic        rd;
        logic        wr;
        logic        br;
        logic        rw;
        logic        zero;
        int          wait_cyc;
        int          exp_cycles;
        int          exp_rf;
        int          exp_dmr;
        int          exp_dmw;
        int          exp_pc_src;
        int          exp_wb_sel;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.CNT_W(32)) bus ();

    multicycle_sequencer #(
        .HALT_OPCODE (10'h3FF),
        .MEM_TIMEOUT (16),
        .CNT_W       (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[8];
    vec_t sb_q[$];
    longint exp_instr = 0;
    longint exp_cyc   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int id, input logic [9:0] op, input logic rd, input logic wr,
                                input logic br, input logic rw, input logic zero, input int wt,
                                input int cyc, input int rf, input int dmr, input int dmw,
                                input int pcs, input int wbs);
        vec_t v;
        v.id = id; v.opcode = op; v.rd = rd; v.wr = wr; v.br = br; v.rw = rw; v.zero = zero;
        v.wait_cyc = wt; v.exp_cycles = cyc; v.exp_rf = rf; v.exp_dmr = dmr; v.exp_dmw = dmw;
        v.exp_pc_src = pcs; v.exp_wb_sel = wbs;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.stop_req = 1'b0; bus.opcode = 10'h458;
        bus.dec_mem_read = 1'b0; bus.dec_mem_write = 1'b0; bus.dec_branch = 1'b0;
        bus.dec_reg_write = 1'b0; bus.alu_zero = 1'b0; bus.dm_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_instr(input logic [9:0] op, input logic rd, input logic wr,
                             input logic br, input logic rw, input logic zero);
        bus.opcode = op; bus.dec_mem_read = rd; bus.dec_mem_write = wr;
        bus.dec_branch = br; bus.dec_reg_write = rw; bus.alu_zero = zero;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc = 0, rf = 0, dmr = 0, dmw = 0, pcw = 0, pcs = 0, wbs = 0, viol = 0, mem_seen = 0;
        bit   done = 0;
        vec_t e;
        @(negedge clk);
        set_instr(v.opcode, v.rd, v.wr, v.br, v.rw, v.zero);
        bus.stop_req = 1'b1;
        bus.start    = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.state == 3'd0) begin done = 1; break; end
            if (bus.busy)     cyc++;
            if (bus.rf_write) begin rf++; wbs = wbs | int'(bus.wb_sel); end
            if (bus.dm_read)  dmr++;
            if (bus.dm_write) dmw++;
            if (bus.pc_write) begin pcw++; pcs = int'(bus.pc_src); end
            if ((bus.dm_read && bus.dm_write) || (bus.rf_write && bus.pc_write)) viol++;
            if (bus.state == 3'(S_MEM)) begin
                mem_seen++;
                bus.dm_ready = (mem_seen > v.wait_cyc);
            end else begin
                bus.dm_ready = 1'b0;
            end
            @(negedge clk);
        end
        e = sb_q.pop_front();
        check($sformatf("v%0d_done", e.id), longint'(done), 1);
        check($sformatf("v%0d_cycles", e.id), cyc, e.exp_cycles);
        check($sformatf("v%0d_rf_write", e.id), rf, e.exp_rf);
        check($sformatf("v%0d_dm_read", e.id), dmr, e.exp_dmr);
        check($sformatf("v%0d_dm_write", e.id), dmw, e.exp_dmw);
        check($sformatf("v%0d_pc_write", e.id), pcw, 1);
        check($sformatf("v%0d_pc_src", e.id), pcs, e.exp_pc_src);
        check($sformatf("v%0d_wb_sel", e.id), wbs, e.exp_wb_sel);
        check($sformatf("v%0d_exclusive", e.id), viol, 0);
        exp_instr += 1;
        exp_cyc   += e.exp_cycles;
        check($sformatf("v%0d_instr_count", e.id), longint'(bus.instr_count), exp_instr);
        check($sformatf("v%0d_cycle_count", e.id), longint'(bus.cycle_count), exp_cyc);
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b0;
        idle_inputs();
        //            id  opcode   rd wr br rw z  wait cyc rf dmr dmw pcs wbs
        vecs[0] = mk(0, 10'h458, 0, 0, 0, 1, 0, 0,   5, 1, 0,  0,  0,  0);  // ADD
        vecs[1] = mk(1, 10'h7C2, 1, 0, 0, 1, 0, 3,   9, 1, 4,  0,  0,  1);  // LDUR, 3 waits
        vecs[2] = mk(2, 10'h7C2, 1, 0, 0, 1, 0, 0,   6, 1, 1,  0,  0,  1);  // LDUR immediate
        vecs[3] = mk(3, 10'h7C0, 0, 1, 0, 0, 0, 0,   5, 0, 0,  1,  0,  0);  // STUR immediate
        vecs[4] = mk(4, 10'h7C0, 0, 1, 0, 0, 0, 2,   7, 0, 0,  3,  0,  0);  // STUR, 2 waits
        vecs[5] = mk(5, 10'h5A0, 0, 0, 1, 0, 1, 0,   4, 0, 0,  0,  1,  0);  // CBZ taken
        vecs[6] = mk(6, 10'h5A0, 0, 0, 1, 0, 0, 0,   4, 0, 0,  0,  0,  0);  // CBZ not taken
        vecs[7] = mk(7, 10'h7C2, 1, 0, 0, 1, 0, 15, 21, 1, 16, 0,  0,  1);  // ready on last allowed cycle

        repeat (3) @(negedge clk);
        check("reset_state", longint'(bus.state), 0);
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_halted_fault", longint'({bus.halted, bus.fault}), 0);
        check("reset_strobes", longint'({bus.ir_load, bus.pc_write, bus.pc_src, bus.rf_write,
                                         bus.wb_sel, bus.dm_read, bus.dm_write}), 0);
        check("reset_counters", longint'(bus.cycle_count) + longint'(bus.instr_count), 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // stop_req low in NEXT_PC continues to FETCH
        do_reset();
        @(negedge clk);
        set_instr(10'h458, 0, 0, 0, 1, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.pc_write) seen = 1;
            @(negedge clk);
        end
        check("nostop_pc_write_seen", longint'(seen), 1);
        check("nostop_next_fetch", longint'(bus.state), 1);
        bus.stop_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.state == 3'd0) seen = 1;
            else @(negedge clk);
        end
        check("stop_idle", longint'(seen), 1);
        check("stop_instr_count", longint'(bus.instr_count), 2);
        check("stop_cycle_count", longint'(bus.cycle_count), 10);

        // halt opcode
        do_reset();
        @(negedge clk);
        set_instr(10'h3FF, 0, 0, 0, 1, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("halt_fetch", longint'(bus.state), 1);
        @(negedge clk);
        check("halt_decode", longint'(bus.state), 2);
        @(negedge clk);
        check("halt_halted", longint'(bus.halted), 1);
        check("halt_state", longint'(bus.state), 7);
        check("halt_fault", longint'(bus.fault), 0);
        check("halt_instr_count", longint'(bus.instr_count), 0);
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        check("halt_start_ignored", longint'({bus.state, bus.halted, bus.busy}), longint'({3'd7, 1'b1, 1'b0}));

        // decode with both memory flags
        do_reset();
        @(negedge clk);
        set_instr(10'h7C2, 1, 1, 0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("both_fault", longint'(bus.fault), 1);
        check("both_halted", longint'(bus.halted), 0);
        check("both_state", longint'(bus.state), 7);
        check("both_dm_strobes", longint'({bus.dm_read, bus.dm_write}), 0);

        // store that never sees dm_ready
        do_reset();
        @(negedge clk);
        set_instr(10'h7C0, 0, 1, 0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && !bus.fault; c++) begin
            if (bus.dm_write) n++;
            @(negedge clk);
        end
        check("timeout_dm_write_cycles", n, 16);
        check("timeout_fault", longint'(bus.fault), 1);
        check("timeout_strobes", longint'({bus.dm_read, bus.dm_write, bus.rf_write, bus.pc_write}), 0);
        check("timeout_busy", longint'(bus.busy), 0);
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        check("timeout_start_ignored", longint'({bus.state, bus.fault}), longint'({3'd7, 1'b1}));
        check("timeout_instr_count", longint'(bus.instr_count), 0);

        // asynchronous reset in the middle of a store
        do_reset();
        @(negedge clk);
        set_instr(10'h7C0, 0, 1, 0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.state == 3'(S_MEM)) seen = 1;
            else @(negedge clk);
        end
        check("midreset_reached_mem", longint'(seen), 1);
        repeat (2) @(negedge clk);
        check("midreset_dm_write_before", longint'(bus.dm_write), 1);
        reset = 1'b0;
        #1;
        check("midreset_dm_write_after", longint'(bus.dm_write), 0);
        check("midreset_state", longint'(bus.state), 0);
        check("midreset_counters", longint'(bus.cycle_count) + longint'(bus.instr_count), 0);
        check("midreset_pc_rf", longint'({bus.pc_write, bus.rf_write}), 0);
        @(negedge clk);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
